// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with a held one-hot grant.
// The grant is released on done or by an optional hold timeout.
module rr_grant_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDXW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             done,
    output logic [WIDTH-1:0] grant,
    output logic [IDXW-1:0]  grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] grant_nx;
    logic [IDXW-1:0]  grant_idx_nx;
    logic             grant_valid_nx;
    logic             timeout_nx;
    logic [HW-1:0]    hold_cnt, hold_cnt_nx;
    logic [IDXW-1:0]  last_idx, last_idx_nx;

    logic [WIDTH-1:0] hi_mask;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] pool;
    logic [WIDTH-1:0] winner;
    logic [IDXW-1:0]  win_idx;

    // Requesters above the last owner go first; otherwise wrap to the bottom.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hi_mask[i] = (i > int'(last_idx));
        end
        masked = req & hi_mask;
        pool   = (masked != '0) ? masked : req;
        winner = pool & (~pool + WIDTH'(1));
        win_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (winner[i]) begin
                win_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        state_nx       = state;
        grant_nx       = grant;
        grant_idx_nx   = grant_idx;
        grant_valid_nx = grant_valid;
        timeout_nx     = 1'b0;
        hold_cnt_nx    = hold_cnt;
        last_idx_nx    = last_idx;
        unique case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nx       = GRANT;
                    grant_nx       = winner;
                    grant_idx_nx   = win_idx;
                    grant_valid_nx = 1'b1;
                    hold_cnt_nx    = '0;
                end
            end
            GRANT: begin
                if (done) begin
                    state_nx       = IDLE;
                    last_idx_nx    = grant_idx;
                    grant_nx       = '0;
                    grant_idx_nx   = '0;
                    grant_valid_nx = 1'b0;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                    state_nx       = IDLE;
                    last_idx_nx    = grant_idx;
                    grant_nx       = '0;
                    grant_idx_nx   = '0;
                    grant_valid_nx = 1'b0;
                    timeout_nx     = 1'b1;
                end else begin
                    hold_cnt_nx = hold_cnt + HW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
            last_idx    <= IDXW'(WIDTH - 1);
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            grant_idx   <= grant_idx_nx;
            grant_valid <= grant_valid_nx;
            timeout     <= timeout_nx;
            hold_cnt    <= hold_cnt_nx;
            last_idx    <= last_idx_nx;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic
// checked against a rotating-search reference model.
module tb_rr_grant_arbiter;

    localparam int W  = 4;
    localparam int MH = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] req = '0;
    logic         done = 1'b0;
    logic [W-1:0] grant;
    logic [1:0]   grant_idx;
    logic         grant_valid;
    logic         timeout;

    int total = 0;
    int bad   = 0;

    int m_own  = -1;
    int m_last = W - 1;
    int m_cnt  = 0;
    bit m_to   = 1'b0;

    rr_grant_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .grant(grant),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Search upward from the requester after the last owner, wrapping once.
    function automatic int pick(logic [W-1:0] r, int last);
        for (int k = 1; k <= W; k++) begin
            int j;
            j = (last + k) % W;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] exp_grant();
        logic [W-1:0] g;
        g = '0;
        if (m_own >= 0) g[m_own] = 1'b1;
        return g;
    endfunction

    function automatic int exp_idx();
        return (m_own < 0) ? 0 : m_own;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_last = W - 1;
        m_cnt = 0;
        m_to = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] r, input logic d);
        m_to = 1'b0;
        if (m_own < 0) begin
            if (r != '0) begin
                m_own = pick(r, m_last);
                m_cnt = 0;
            end
        end else if (d) begin
            m_last = m_own;
            m_own = -1;
        end else if (MH != 0 && m_cnt == MH - 1) begin
            m_last = m_own;
            m_own = -1;
            m_to = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic cyc(input logic [W-1:0] r, input logic d);
        @(negedge clk);
        req = r;
        done = d;
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(r, d);
        #1;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        done = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", grant); end
        total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", grant_idx); end
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", grant_valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout); end
        @(negedge clk);
        rst = 1'b1;
        cyc(4'b1010, 1'b0);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL prio_grant got=%b want=0010", grant); end
        total++; if (grant_idx !== 2'd1) begin bad++; $display("FAIL prio_idx got=%0d want=1", grant_idx); end
        total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL prio_valid got=%b want=1", grant_valid); end
    endtask

    task automatic test_rotation();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        hard_reset();
        for (int g = 0; g < 5; g++) begin
            cyc(4'b1111, 1'b0);
            total++; if (grant !== seq[g]) begin bad++; $display("FAIL rot_grant[%0d] got=%b want=%b", g, grant, seq[g]); end
            total++; if (grant !== exp_grant()) begin bad++; $display("FAIL rot_model[%0d] got=%b want=%b", g, grant, exp_grant()); end
            cyc(4'b1111, 1'b0);
            total++; if (grant !== seq[g]) begin bad++; $display("FAIL rot_hold[%0d] got=%b want=%b", g, grant, seq[g]); end
            cyc(4'b1111, 1'b1);
            total++; if (grant_valid !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL rot_bubble[%0d] got=%b/%b want=0/0000", g, grant_valid, grant); end
        end
    endtask

    task automatic test_wrap();
        hard_reset();
        cyc(4'b0100, 1'b0);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL wrap_first got=%b want=0100", grant); end
        cyc(4'b0000, 1'b1);
        cyc(4'b0101, 1'b0);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wrap_fallback got=%b want=0001", grant); end
        total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL wrap_idx got=%0d want=0", grant_idx); end
        cyc(4'b0000, 1'b1);
        cyc(4'b0101, 1'b0);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL wrap_next got=%b want=0100", grant); end
        cyc(4'b0000, 1'b1);
    endtask

    task automatic test_timeout();
        int n;
        hard_reset();
        cyc(4'b0100, 1'b0);
        n = 0;
        for (int k = 0; k < 10 && grant_valid; k++) begin
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", timeout); end
            n++;
            cyc(4'b0000, 1'b0);
        end
        total++; if (n != MH) begin bad++; $display("FAIL to_len got=%0d want=%0d", n, MH); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", timeout); end
        cyc(4'b1111, 1'b0);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_single got=%b want=0", timeout); end
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL to_next got=%b want=1000", grant); end
        cyc(4'b0000, 1'b1);
    endtask

    task automatic test_collision();
        hard_reset();
        cyc(4'b0010, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL col_hold got=%b want=0010", grant); end
        cyc(4'b0000, 1'b1);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL col_timeout got=%b want=0", timeout); end
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL col_release got=%b want=0", grant_valid); end
        cyc(4'b1000, 1'b0);
        cyc(4'b0000, 1'b0);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL drop_hold got=%b want=1000", grant); end
        cyc(4'b0000, 1'b1);
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL drop_release got=%b want=0", grant_valid); end
    endtask

    task automatic test_async_reset();
        hard_reset();
        cyc(4'b1000, 1'b0);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL ar_pre got=%b want=1000", grant); end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (grant !== 4'b0000 || grant_idx !== 2'd0) begin bad++; $display("FAIL ar_clear got=%b/%0d want=0000/0", grant, grant_idx); end
        total++; if (grant_valid !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL ar_flags got=%b/%b want=0/0", grant_valid, timeout); end
        @(negedge clk);
        rst = 1'b1;
        cyc(4'b1000, 1'b0);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL ar_regrant got=%b want=1000", grant); end
        cyc(4'b0000, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] r;
        logic         d;
        logic         prev_to;
        hard_reset();
        prev_to = 1'b0;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(4) == 0) ? '0 : W'($urandom);
            d = ($urandom_range(3) == 0);
            cyc(r, d);
            total++; if (grant !== exp_grant()) begin bad++; $display("FAIL rnd_grant[%0d] got=%b want=%b", c, grant, exp_grant()); end
            total++; if (int'(grant_idx) != exp_idx()) begin bad++; $display("FAIL rnd_idx[%0d] got=%0d want=%0d", c, grant_idx, exp_idx()); end
            total++; if (grant_valid !== (m_own >= 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", c, grant_valid, m_own >= 0); end
            total++; if (timeout !== m_to) begin bad++; $display("FAIL rnd_timeout[%0d] got=%b want=%b", c, timeout, m_to); end
            total++; if (grant_valid !== (|grant) || !$onehot0(grant)) begin bad++; $display("FAIL rnd_inv[%0d] got=%b/%b want=onehot0 and consistent", c, grant_valid, grant); end
            total++; if (prev_to && timeout) begin bad++; $display("FAIL rnd_to2[%0d] got=11 want=not both", c); end
            prev_to = timeout;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Registered round-robin arbiter that consumes a multi-bit request vector and produces a held one-hot grant.
- Internally it applies lowest-index-wins priority decode to a rotating-masked request vector, so no requester starves.
- It sits between the requesting agents and the shared resource.
- The grant is held until the owner signals done, or until a hold timeout forces release.

Parameters:
- WIDTH, 4: number of requesters. Legal range is at least 2.
- MAX_HOLD, 16: maximum number of cycles a grant may be held. 0 disables the timeout.
- IDXW, $clog2(WIDTH): width of grant_idx. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; all state is cleared immediately while it is low.
- req  input  WIDTH  request vector; bit i high means requester i wants the resource.
- done  input  1  single-cycle release pulse from the current owner.
- grant  output  WIDTH  registered one-hot grant; all zero when idle.
- grant_idx  output  IDXW  binary index of the granted bit; 0 when idle.
- grant_valid  output  1  high exactly when grant is nonzero.
- timeout  output  1  single-cycle pulse when a grant is force-released.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; grant=0, grant_idx=0, grant_valid=0, timeout=0; hold_cnt=0.
  - last_idx=WIDTH-1, so requester 0 has highest priority after reset.
  - rst deasserting mid-operation simply leaves the block in IDLE; no grant is carried over.
- Arbitration (combinational, evaluated in IDLE only):
  - masked = req AND (bits with index > last_idx).
  - If masked is nonzero, winner = lowest set bit of masked. Otherwise winner = lowest set bit of req.
  - The winner is one-hot, or zero when req=0.
- States:
  - IDLE:
    - If req is nonzero: next state GRANT; grant<=winner; grant_idx<=encode(winner); grant_valid<=1; hold_cnt<=0.
    - If req=0: remain in IDLE with outputs held at 0.
    - done is ignored in IDLE.
  - GRANT:
    - grant, grant_idx and grant_valid are held constant. There is no preemption.
    - A change in req, including the owner dropping its req, has no effect on the grant.
    - If done=1: next state IDLE; last_idx<=grant_idx; grant, grant_idx and grant_valid are cleared next cycle.
    - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: next state IDLE; last_idx<=grant_idx; outputs are cleared; timeout<=1 for exactly one cycle.
    - Else: hold_cnt<=hold_cnt+1.
    - done and the timeout condition in the same cycle: done wins and timeout stays 0.
- Latency:
  - A request present in IDLE at edge k produces a grant visible after edge k.
  - After release there is a mandatory one-cycle IDLE bubble before the next grant.
  - Minimum re-grant spacing is therefore 2 cycles.
- Hold duration: with MAX_HOLD=M and no done, grant_valid is high for exactly M cycles.
- Width rules:
  - hold_cnt width is $clog2(MAX_HOLD+1), minimum 1 bit.
  - The comparison is unsigned. The counter never wraps, because release happens at MAX_HOLD-1.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_idx matches grant.
  - timeout is never high in two consecutive cycles.

Test Plan:
- Reset priority: rst low then high, WIDTH=4, req=4'b1010 → grant=4'b0010 one cycle later; grant_idx=1; grant_valid=1.
- Round-robin rotation: req held at 4'b1111 with a done pulse on the second cycle of each grant → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant is separated by one idle cycle.
- Wrap and mask fallback: last_idx=2, req=4'b0101 → masked=0, so fallback selects bit 0 and grant=4'b0001. Next grant with req=4'b0101 → grant=4'b0100.
- Timeout: MAX_HOLD=3, req=4'b0100, done never pulsed → grant high for exactly 3 cycles; timeout=1 on the first cycle after release; the next arbitration starts from last_idx=2.
- Done/timeout collision and hold: MAX_HOLD=3, done on the 3rd grant cycle → release with timeout=0. Separately, the owner drops req mid-grant → grant is held until done.
- Async reset mid-grant: rst low while grant=4'b1000 → all outputs are 0 immediately, before the next clk edge. After rst releases with req=4'b1000 → grant=4'b1000 again.
